pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 36 +++
 rtl/pipeline_ctrl_sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: control FSM encoding, forwarding-mux selects
// and the bundle of pipeline-register enables/flushes.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DWAIT = 1'b1
    } ctrl_state_e;

    localparam logic [1:0] FORWARD_NONE   = 2'b00;
    localparam logic [1:0] FORWARD_MEM_WB = 2'b01;
    localparam logic [1:0] FORWARD_EX_MEM = 2'b10;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic back_write;
        logic mem_wb_flush;
    } ctrl_bus_t;

    localparam ctrl_bus_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b0, back_write: 1'b1, mem_wb_flush: 1'b0};
    localparam ctrl_bus_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b0, back_write: 1'b0, mem_wb_flush: 1'b1};
    localparam ctrl_bus_t CTRL_HAZARD = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                          id_ex_flush: 1'b1, back_write: 1'b1, mem_wb_flush: 1'b0};
    localparam ctrl_bus_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                          id_ex_flush: 1'b0, back_write: 1'b1, mem_wb_flush: 1'b0};
    localparam ctrl_bus_t CTRL_IMEM   = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1,
                                          id_ex_flush: 1'b0, back_write: 1'b1, mem_wb_flush: 1'b0};
    localparam ctrl_bus_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                          id_ex_flush: 1'b1, back_write: 1'b0, mem_wb_flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    // Count register with saturation at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= {W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: arbitrates memory freeze, hazard stalls,
// branch flushes and fetch waits into register enables/flushes, plus perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Back_Write,
    output logic             MEM_WB_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    // The RUN cycle that starts the access already counts as wait cycle one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    ctrl_state_e       state_r;
    ctrl_state_e       state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_err_r;
    logic              timeout_s;
    logic              branch_flush_s;
    ctrl_bus_t         ctrl_s;

    // Next-state and priority-encoded control outputs.
    always_comb begin
        state_nxt_s    = state_r;
        ctrl_s         = CTRL_NORMAL;
        timeout_s      = 1'b0;
        branch_flush_s = 1'b0;
        if (!rstn) begin
            ctrl_s = CTRL_RESET;
        end else begin
            case (state_r)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        ctrl_s      = CTRL_FREEZE;
                        state_nxt_s = DWAIT;
                    end else if (hazard_stall) begin
                        ctrl_s = CTRL_HAZARD;
                    end else if (branch_taken) begin
                        ctrl_s         = CTRL_BRANCH;
                        branch_flush_s = 1'b1;
                    end else if (!imem_ready) begin
                        ctrl_s = CTRL_IMEM;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                DWAIT: begin
                    if (dmem_ready) begin
                        ctrl_s      = CTRL_NORMAL;
                        state_nxt_s = RUN;
                    end else if (wait_cnt_r >= WAIT_LAST) begin
                        ctrl_s      = CTRL_FREEZE;
                        timeout_s   = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        ctrl_s      = CTRL_FREEZE;
                        state_nxt_s = DWAIT;
                    end
                end
                default: begin
                    ctrl_s      = CTRL_RESET;
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mem_err_r <= mem_err_r | timeout_s;
            if ((state_r == RUN) && (state_nxt_s == DWAIT)) begin
                wait_cnt_r <= WAIT_ONE;
            end else if ((state_r == DWAIT) && (state_nxt_s == DWAIT)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
        end
    end

    assign PC_Write     = ctrl_s.pc_write;
    assign IF_ID_Write  = ctrl_s.if_id_write;
    assign IF_ID_Flush  = ctrl_s.if_id_flush;
    assign ID_EX_Flush  = ctrl_s.id_ex_flush;
    assign Back_Write   = ctrl_s.back_write;
    assign MEM_WB_Flush = ctrl_s.mem_wb_flush;
    assign mem_err      = mem_err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (~ctrl_s.pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (branch_flush_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: scoreboarded control outputs plus counter
// models, run against a default instance and a 4-bit-counter instance.
module tb_pipeline_ctrl;

    localparam logic [5:0] P_NORMAL = 6'b110010;
    localparam logic [5:0] P_FREEZE = 6'b000001;
    localparam logic [5:0] P_HAZARD = 6'b000110;
    localparam logic [5:0] P_BRANCH = 6'b111010;
    localparam logic [5:0] P_IMEM   = 6'b011010;
    localparam logic [5:0] P_RESET  = 6'b001101;

    logic clk = 1'b0;
    logic rstn;
    logic hazard_stall, branch_taken, imem_ready, dmem_req, dmem_ready;

    logic        pc_w_a, ifid_w_a, ifid_f_a, idex_f_a, back_w_a, memwb_f_a, mem_err_a;
    logic [15:0] stall_a, flush_a;
    logic        pc_w_b, ifid_w_b, ifid_f_b, idex_f_b, back_w_b, memwb_f_b, mem_err_b;
    logic [3:0]  stall_b, flush_b;

    int total = 0;
    int bad   = 0;
    int m_stall16 = 0, m_flush16 = 0, m_stall4 = 0, m_flush4 = 0;
    logic exp_mem_err = 1'b0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rstn(rstn), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PC_Write(pc_w_a), .IF_ID_Write(ifid_w_a), .IF_ID_Flush(ifid_f_a),
        .ID_EX_Flush(idex_f_a), .Back_Write(back_w_a), .MEM_WB_Flush(memwb_f_a),
        .mem_err(mem_err_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipeline_ctrl #(.CNT_W(4), .TIMEOUT(64)) dut4 (
        .clk(clk), .rstn(rstn), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PC_Write(pc_w_b), .IF_ID_Write(ifid_w_b), .IF_ID_Flush(ifid_f_b),
        .ID_EX_Flush(idex_f_b), .Back_Write(back_w_b), .MEM_WB_Flush(memwb_f_b),
        .mem_err(mem_err_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_stall"},  {16'h0, stall_a}, m_stall16);
        check({tag, "_flush"},  {16'h0, flush_a}, m_flush16);
        check({tag, "_stall4"}, {28'h0, stall_b}, m_stall4);
        check({tag, "_flush4"}, {28'h0, flush_b}, m_flush4);
        check({tag, "_memerr"}, {31'h0, mem_err_a}, {31'h0, exp_mem_err});
    endtask

    task automatic set_in(input logic hs, input logic bt, input logic im, input logic dq, input logic dr);
        hazard_stall = hs;
        branch_taken = bt;
        imem_ready   = im;
        dmem_req     = dq;
        dmem_ready   = dr;
    endtask

    // One clock of stimulus: drive after the edge, check at the following negedge.
    task automatic step(input string tag, input logic hs, input logic bt, input logic im,
                        input logic dq, input logic dr, input logic [5:0] exp);
        logic [5:0] want;
        @(posedge clk);
        #1;
        set_in(hs, bt, im, dq, dr);
        exp_q.push_back(exp);
        @(negedge clk);
        want = exp_q.pop_front();
        check({tag, "_ctrl"},  {26'h0, pc_w_a, ifid_w_a, ifid_f_a, idex_f_a, back_w_a, memwb_f_a},
              {26'h0, want});
        check({tag, "_ctrl4"}, {26'h0, pc_w_b, ifid_w_b, ifid_f_b, idex_f_b, back_w_b, memwb_f_b},
              {26'h0, want});
        check_state(tag);
        if (!want[5]) begin
            if (m_stall16 < 65535) m_stall16++;
            if (m_stall4 < 15) m_stall4++;
        end
        if (want == P_BRANCH) begin
            if (m_flush16 < 65535) m_flush16++;
            if (m_flush4 < 15) m_flush4++;
        end
    endtask

    task automatic reset_models();
        m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
        exp_mem_err = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        check("rst_ctrl", {26'h0, pc_w_a, ifid_w_a, ifid_f_a, idex_f_a, back_w_a, memwb_f_a},
              {26'h0, P_RESET});
        check_state("rst");
        #9;
        rstn = 1'b1;

        // Basic priority decoding.
        step("norm0",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);
        step("imem",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_IMEM);
        step("br_imem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_BRANCH);
        step("br",      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_BRANCH);
        step("hz_br",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_HAZARD);
        step("dm_hit",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, P_BRANCH);
        step("norm1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);

        // Data-memory wait: 4 frozen cycles, release, back in RUN.
        step("dw_enter", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_FREEZE);
        for (int i = 0; i < 3; i++)
            step("dw_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, P_FREEZE);
        step("dw_rel",  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, P_NORMAL);
        step("dw_run",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);

        // Timeout: 64 frozen cycles then sticky mem_err.
        for (int i = 0; i < 64; i++)
            step("to_wait", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_FREEZE);
        exp_mem_err = 1'b1;
        step("to_run0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);
        step("to_run1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, P_BRANCH);
        step("to_run2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);
        check("mem_err4", {31'h0, mem_err_b}, 32'd1);

        // Reset pulse in the middle of a data-memory wait.
        for (int i = 0; i < 3; i++)
            step("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, P_FREEZE);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        reset_models();
        check("mid_rst_ctrl", {26'h0, pc_w_a, ifid_w_a, ifid_f_a, idex_f_a, back_w_a, memwb_f_a},
              {26'h0, P_RESET});
        check_state("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);
        step("post_rst1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);

        // 20 hazard stalls: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++)
            step("sat", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_HAZARD);
        step("sat_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_NORMAL);
        check("sat4_val",  {28'h0, stall_b}, 32'd15);
        check("sat16_val", {16'h0, stall_a}, 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
